// File: rtl/gcd_arbiter.sv
// Round-robin front end that shares one external GCD unit among N requesters.
// One job in flight at a time; zero operands bypass the unit, and a stalled unit is timed out.
module gcd_arbiter #(
   parameter int N       = 4,
   parameter int W       = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req_valid,
   input  logic [N*W-1:0] req_a,
   input  logic [N*W-1:0] req_b,
   output logic [N-1:0]   req_ready,
   output logic [N-1:0]   rsp_valid,
   output logic [W-1:0]   rsp_data,
   output logic           rsp_err,
   output logic           busy,
   output logic           gcd_go,
   output logic [W-1:0]   gcd_in1,
   output logic [W-1:0]   gcd_in2,
   input  logic [W-1:0]   gcd_out,
   input  logic           gcd_done
);

   localparam int          PW = (N > 1) ? $clog2(N) : 1;
   localparam int          CW = $clog2(TIMEOUT + 1);
   localparam int unsigned NU = N;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t         r_state;
   state_t         w_next;
   logic [PW-1:0]  r_last;
   logic [PW-1:0]  r_tag;
   logic [W-1:0]   r_a;
   logic [W-1:0]   r_b;
   logic [W-1:0]   r_res;
   logic           r_err;
   logic [CW-1:0]  r_cnt;
   logic [PW-1:0]  w_gidx;
   logic           w_any;
   logic [W-1:0]   w_a;
   logic [W-1:0]   w_b;
   logic           w_timeout;

   // Scan offsets from far to near so the nearest valid index after r_last wins.
   always_comb begin
      int unsigned idx;
      idx    = 0;
      w_any  = 1'b0;
      w_gidx = r_last;
      w_a    = '0;
      w_b    = '0;
      for (int unsigned i = NU; i >= 1; i--) begin
         idx = (i + 32'(r_last)) % NU;
         if (req_valid[idx]) begin
            w_any  = 1'b1;
            w_gidx = PW'(idx);
            w_a    = req_a[idx*W +: W];
            w_b    = req_b[idx*W +: W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      req_ready = '0;
      rsp_valid = '0;
      rsp_data  = '0;
      rsp_err   = 1'b0;
      busy      = (r_state != IDLE);
      gcd_go    = 1'b0;
      gcd_in1   = '0;
      gcd_in2   = '0;
      w_timeout = 1'b0;
      case (r_state)
         IDLE: begin
            // Ready is gated by rst so every output is low while reset is held.
            if (rst && w_any) begin
               req_ready[w_gidx] = 1'b1;
               w_next = (w_a == '0 || w_b == '0) ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            gcd_go  = 1'b1;
            gcd_in1 = r_a;
            gcd_in2 = r_b;
            w_next  = WAIT;
         end
         WAIT: begin
            gcd_in1   = r_a;
            gcd_in2   = r_b;
            w_timeout = (r_cnt == CW'(TIMEOUT - 1));
            if (gcd_done || w_timeout) w_next = RESP;
         end
         RESP: begin
            rsp_valid[r_tag] = 1'b1;
            rsp_data         = r_res;
            rsp_err          = r_err;
            w_next           = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_last <= PW'(N - 1);
         r_tag  <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_res  <= '0;
         r_err  <= 1'b0;
         r_cnt  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_a    <= w_a;
                  r_b    <= w_b;
                  r_tag  <= w_gidx;
                  r_last <= w_gidx;
                  r_res  <= w_a | w_b;
                  r_err  <= 1'b0;
               end
            end
            ISSUE: r_cnt <= '0;
            WAIT: begin
               r_cnt <= r_cnt + CW'(1);
               if (gcd_done) begin
                  r_res <= gcd_out;
                  r_err <= 1'b0;
               end else if (w_timeout) begin
                  r_res <= '0;
                  r_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter with a behavioural GCD unit of adjustable latency.
module tb_gcd_arbiter;
   localparam int N  = 4;
   localparam int W  = 32;
   localparam int TO = 16;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N*W-1:0] req_a = '0;
   logic [N*W-1:0] req_b = '0;
   logic [N-1:0]   req_ready, rsp_valid;
   logic [W-1:0]   rsp_data, gcd_in1, gcd_in2;
   logic           rsp_err, busy, gcd_go;
   logic [W-1:0]   gcd_out;
   logic           gcd_done;

   int total = 0;
   int bad = 0;
   int go_count = 0;
   int m_lat = 3;
   int m_cnt = 0;
   int last_cyc = 0;
   bit model_en = 1'b1;
   logic [W-1:0] m_a, m_b;

   gcd_arbiter #(.N(N), .W(W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .busy(busy), .gcd_go(gcd_go), .gcd_in1(gcd_in1), .gcd_in2(gcd_in2),
      .gcd_out(gcd_out), .gcd_done(gcd_done)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] x, y, t;
      x = a;
      y = b;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // GCD unit model: done fires m_lat cycles after the go pulse; result is junk otherwise
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_cnt    <= 0;
         gcd_done <= 1'b0;
         gcd_out  <= '0;
      end else begin
         gcd_done <= 1'b0;
         gcd_out  <= 32'hDEADBEEF;
         if (gcd_go) begin
            go_count <= go_count + 1;
            m_cnt    <= m_lat;
            m_a      <= gcd_in1;
            m_b      <= gcd_in2;
         end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1 && model_en) begin
               gcd_done <= 1'b1;
               gcd_out  <= gcd_f(m_a, m_b);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b0;
      tick;
      tick;
      rst = 1'b1;
      tick;
   endtask

   task automatic run_job(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_d, input bit exp_e, input bit byp,
                          input bit hold, input string tg);
      int g0;
      int cyc;
      logic pd;
      req_valid[idx]       = 1'b1;
      req_a[idx*W +: W]    = a;
      req_b[idx*W +: W]    = b;
      #1;
      chk({tg, ":ready"}, req_ready, 64'(1 << idx));
      g0 = go_count;
      tick;
      if (!hold) req_valid[idx] = 1'b0;
      if (byp) begin
         chk({tg, ":byp_valid"}, rsp_valid, 64'(1 << idx));
         chk({tg, ":byp_data"}, rsp_data, exp_d);
         chk({tg, ":byp_err"}, rsp_err, exp_e);
         chk({tg, ":byp_go"}, gcd_go, 0);
      end else begin
         chk({tg, ":go"}, {gcd_go, gcd_in1, gcd_in2}, {1'b1, a, b});
         tick;
         chk({tg, ":wait"}, {gcd_go, busy, gcd_in1}, {1'b0, 1'b1, a});
         pd  = 1'b0;
         cyc = 0;
         while (cyc < 200 && rsp_valid == '0) begin
            pd = gcd_done;
            tick;
            cyc++;
         end
         last_cyc = cyc;
         chk({tg, ":rsp_valid"}, rsp_valid, 64'(1 << idx));
         chk({tg, ":rsp_data"}, rsp_data, exp_d);
         chk({tg, ":rsp_err"}, rsp_err, exp_e);
         if (!exp_e) chk({tg, ":done_to_rsp"}, pd, 1);
      end
      tick;
      chk({tg, ":after"}, {busy, rsp_valid, rsp_err, rsp_data}, 0);
      chk({tg, ":go_count"}, go_count - g0, byp ? 0 : 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int a37[4];
      int b37[4];
      int e37[4];
      a37 = '{40, 12, 7, 100};
      b37 = '{5, 18, 13, 75};
      e37 = '{5, 6, 1, 25};

      rst = 1'b0;
      req_valid = '1;
      req_a = '1;
      req_b = '1;
      #3;
      chk("rst_ready", req_ready, 0);
      chk("rst_ctl", {busy, gcd_go, rsp_valid, rsp_err}, 0);
      chk("rst_data", {rsp_data, gcd_in1}, 0);
      chk("rst_in2", gcd_in2, 0);
      req_valid = '0;
      tick;
      rst = 1'b1;
      tick;

      run_job(0, 21, 3, 3, 0, 0, 0, "p0_21_3");

      // request withdrawn before the edge: no grant, no job
      req_valid[2] = 1'b1;
      #1;
      chk("withdraw_ready", req_ready, 4'b0100);
      #1;
      req_valid = '0;
      #1;
      chk("withdraw_ready_low", req_ready, 0);
      tick;
      chk("withdraw_idle", {busy, rsp_valid}, 0);

      do_reset;
      for (int k = 0; k < 4; k++) begin
         req_a[k*W +: W] = a37[k];
         req_b[k*W +: W] = b37[k];
      end
      req_valid = '1;
      for (int k = 0; k < 4; k++)
         run_job(k, a37[k], b37[k], e37[k], 0, 0, 0, $sformatf("all4_p%0d", k));

      run_job(2, 0, 9, 9, 0, 1, 0, "byp_0_9");
      run_job(3, 7, 0, 7, 0, 1, 0, "byp_7_0");

      model_en = 1'b0;
      run_job(1, 6, 4, 0, 1, 0, 0, "timeout");
      chk("timeout_len", last_cyc, TO);
      model_en = 1'b1;
      run_job(3, 9, 6, 3, 0, 0, 0, "post_timeout");

      m_lat = 15;
      run_job(0, 14, 21, 7, 0, 0, 0, "coincide");
      chk("coincide_len", last_cyc, TO);
      m_lat = 16;
      run_job(2, 8, 12, 0, 1, 0, 0, "late_done");
      m_lat = 3;

      // reset while waiting on the unit
      req_valid[1] = 1'b1;
      req_a[1*W +: W] = 40;
      req_b[1*W +: W] = 5;
      tick;
      req_valid = '0;
      tick;
      chk("midrst_wait", {busy, gcd_in1}, {1'b1, 32'd40});
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_out", {busy, gcd_go, rsp_valid, rsp_err, req_ready}, 0);
      chk("midrst_data", {rsp_data, gcd_in1}, 0);
      tick;
      tick;
      chk("midrst_norsp", {rsp_valid, busy}, 0);
      rst = 1'b1;
      tick;
      run_job(1, 40, 5, 5, 0, 0, 0, "post_rst");

      do_reset;
      req_a[0*W +: W] = 8;
      req_b[0*W +: W] = 12;
      req_a[3*W +: W] = 0;
      req_b[3*W +: W] = 5;
      req_valid = 4'b1001;
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) run_job(0, 8, 12, 4, 0, 0, 1, $sformatf("rr_%0d_p0", k));
         else            run_job(3, 0, 5, 5, 0, 1, 1, $sformatf("rr_%0d_p3", k));
      end
      req_valid = '0;
      tick;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
